iir_coef_loader: RTL and testbench
==================================

IIR_COEF_LOADER -- requirements
Module: iir_coef_loader

Interface
REQ-001 SHALL provide parameter NB, default 21, number of feed-forward coefficients b0..b(NB-1).
REQ-002 SHALL provide parameter NA, default 14, number of feedback coefficients a1..aNA.
REQ-003 SHALL provide parameter W, default 16, coefficient width in bits.
REQ-004 SHALL provide port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL provide port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide port: wr_valid  in  1  host write request.
REQ-007 SHALL provide port: wr_ready  out  1  loader can accept a write.
REQ-008 SHALL provide port: wr_addr  in  6  coefficient/register address.
REQ-009 SHALL provide port: wr_data  in  W  write data.
REQ-010 SHALL provide port: commit  in  1  single-cycle request to publish the shadow bank.
REQ-011 SHALL provide port: sample_tick  in  1  single-cycle strobe, one per filter input sample.
REQ-012 SHALL provide port: b_coef  out  NB*W  active b coefficients, b0 in bits [W-1:0].
REQ-013 SHALL provide port: a_coef  out  NA*W  active a coefficients, a1 in bits [W-1:0].
REQ-014 SHALL provide port: order  out  4  active filter order.
REQ-015 SHALL provide port: coef_valid  out  1  at least one commit has completed since reset.
REQ-016 SHALL provide port: pending  out  1  commit requested, swap not yet done.
REQ-017 SHALL provide port: err  out  1  one-cycle pulse on a rejected write.
REQ-018 SHALL provide port: swap_count  out  8  number of completed swaps, wraps 255->0.

Function
REQ-019 SHALL hold two banks: shadow (host-written) and active (driving b_coef, a_coef, order).
REQ-020 SHALL accept a write when wr_valid and wr_ready are both high at a rising edge.
REQ-021 SHALL map addresses 0..NB-1 to shadow b0..b(NB-1), NB..NB+NA-1 to shadow a1..aNA, and 35 to shadow order from wr_data[3:0].
REQ-022 SHALL drop an accepted write to an unmapped address (36..63), or to address 35 with wr_data[3:0] > 10, leaving shadow unchanged, and SHALL pulse err high for the following cycle.
REQ-023 SHALL implement FSM IDLE -> PENDING on commit; PENDING -> IDLE on sample_tick, with active <= shadow on that edge.
REQ-024 SHALL drive wr_ready = 1 in IDLE and 0 in PENDING, so the shadow is frozen while a swap is pending.
REQ-025 SHALL, when a write and commit are accepted in the same cycle, include that write in the committed bank.
REQ-026 SHALL, when commit and sample_tick coincide in IDLE, enter PENDING only; the swap occurs on the next sample_tick, never within the current sample.
REQ-027 SHALL ignore commit while in PENDING.
REQ-028 SHALL drive pending = 1 exactly while the FSM is in PENDING.
REQ-029 SHALL update b_coef, a_coef and order atomically, all changing on the same edge, only at a swap.
REQ-030 SHALL set coef_valid on the first swap and hold it until reset.
REQ-031 SHALL increment swap_count by 1 per swap, modulo 256.
REQ-032 SHALL leave the active bank unchanged by writes and by sample_tick in IDLE.

Reset
REQ-033 SHALL, while reset is low, asynchronously clear both banks, b_coef, a_coef, order, coef_valid, pending, err and swap_count to 0, and force the FSM to IDLE.
REQ-034 SHALL drive wr_ready = 1 from the first clock edge after reset deasserts.
REQ-035 SHALL discard a pending commit and any partial shadow contents when reset asserts mid-operation.

Verification
REQ-036 SHALL verify: write b0=5, b1=8, b2=5, a1=0xF8E2, a2=0x07EB, order=2, then commit, then sample_tick -> after the tick edge b_coef[15:0]=5, b_coef[31:16]=8, a_coef[15:0]=0xF8E2, order=2, coef_valid=1, swap_count=1.
REQ-037 SHALL verify: commit with no sample_tick for 50 cycles -> pending=1, wr_ready=0, outputs unchanged; a write attempted meanwhile is not accepted.
REQ-038 SHALL verify: write to addr 40, and order=12 to addr 35 -> err pulses one cycle each; shadow is unchanged, confirmed by a later commit/tick.
REQ-039 SHALL verify: commit and sample_tick in the same cycle -> no swap then; swap on the next sample_tick.
REQ-040 SHALL verify: reset pulsed low during PENDING -> all outputs 0, pending=0, wr_ready=1 after release; a subsequent tick causes no swap.
REQ-041 SHALL verify: 256 commit/tick pairs -> swap_count wraps to 0 and coef_valid stays 1.

Source files
------------

// File: rtl/iir_coef_loader.sv
// Double-buffered IIR coefficient loader. The host fills a shadow bank via a
// valid/ready write port, then requests a commit. The shadow is copied into
// the active bank on the next sample_tick, so the filter never sees a
// coefficient set that is half old and half new.
//
// Address map (defaults NB=21, NA=14):
//   0 .. NB-1        shadow b0 .. b(NB-1)
//   NB .. NB+NA-1    shadow a1 .. aNA
//   35               shadow order, wr_data[3:0], legal values 0..10
//   anything else    rejected, err pulses for one cycle
//
// Write handshake: a transfer happens on a rising edge where wr_valid and
// wr_ready are both high; wr_ready is high only in IDLE, so the host may hold
// wr_valid and its address/data steady until it sees wr_ready.
module iir_coef_loader #(
   parameter int NB = 21,
   parameter int NA = 14,
   parameter int W  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [5:0]      wr_addr,
   input  logic [W-1:0]    wr_data,
   input  logic            commit,
   input  logic            sample_tick,
   output logic [NB*W-1:0] b_coef,
   output logic [NA*W-1:0] a_coef,
   output logic [3:0]      order,
   output logic            coef_valid,
   output logic            pending,
   output logic            err,
   output logic [7:0]      swap_count,
   output logic            state_dbg
);

   localparam logic [5:0] B_END      = 6'(NB);
   localparam logic [5:0] A_END      = 6'(NB + NA);
   localparam logic [5:0] ORDER_ADDR = 6'd35;
   localparam logic [3:0] MAX_ORDER  = 4'd10;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              swap;
   logic              ready_q;

   logic [NB*W-1:0]   sh_b;
   logic [NA*W-1:0]   sh_a;
   logic [3:0]        sh_order;

   logic              wr_fire;
   logic              hit_b;
   logic              hit_a;
   logic              hit_order;
   logic              bad_wr;

   // ready_q holds wr_ready low during reset and rises at the first edge after release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ready_q <= 1'b0;
      else        ready_q <= 1'b1;
   end

   assign wr_ready  = ready_q && (state == IDLE);
   assign pending   = (state == PENDING);
   assign state_dbg = state;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state; a tick in the same cycle as the commit does not swap, and
   // commit is ignored while a swap is already pending
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      case (state)
         IDLE: begin
            if (commit) state_nxt = PENDING;
         end
         PENDING: begin
            if (sample_tick) begin
               state_nxt = IDLE;
               swap      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address decode for an accepted write; order above 10 counts as unmapped
   always_comb begin
      wr_fire   = wr_valid && wr_ready;
      hit_b     = (wr_addr < B_END);
      hit_a     = (wr_addr >= B_END) && (wr_addr < A_END);
      hit_order = (wr_addr == ORDER_ADDR) && (wr_data[3:0] <= MAX_ORDER);
      bad_wr    = !(hit_b || hit_a || hit_order);
   end

   // Shadow bank: host writes land here, only while IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_b     <= '0;
         sh_a     <= '0;
         sh_order <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < NB; i++) begin
            if (hit_b && (wr_addr == 6'(i))) sh_b[i*W +: W] <= wr_data;
         end
         for (int j = 0; j < NA; j++) begin
            if (hit_a && (wr_addr == 6'(NB + j))) sh_a[j*W +: W] <= wr_data;
         end
         if (hit_order) sh_order <= wr_data[3:0];
      end
   end

   // One-cycle error pulse after a rejected write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err <= 1'b0;
      else        err <= wr_fire && bad_wr;
   end

   // Active bank and swap bookkeeping, all updated on the swap edge together
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_coef     <= '0;
         a_coef     <= '0;
         order      <= '0;
         coef_valid <= 1'b0;
         swap_count <= '0;
      end else if (swap) begin
         b_coef     <= sh_b;
         a_coef     <= sh_a;
         order      <= sh_order;
         coef_valid <= 1'b1;
         swap_count <= swap_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_iir_coef_loader.sv
// Bench for iir_coef_loader: a host-side model of the shadow bank and FSM
// predicts each swap; predictions are queued when the swapping tick is
// driven and compared when the DUT's active outputs change.
module tb_iir_coef_loader;

   localparam int NB = 21;
   localparam int NA = 14;
   localparam int W  = 16;
   localparam int EW = 1 + 8 + 4 + NA*W + NB*W;

   logic            clk;
   logic            reset;
   logic            wr_valid;
   logic            wr_ready;
   logic [5:0]      wr_addr;
   logic [W-1:0]    wr_data;
   logic            commit;
   logic            sample_tick;
   logic [NB*W-1:0] b_coef;
   logic [NA*W-1:0] a_coef;
   logic [3:0]      order;
   logic            coef_valid;
   logic            pending;
   logic            err;
   logic [7:0]      swap_count;
   logic            state_dbg;

   iir_coef_loader #(.NB(NB), .NA(NA), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .commit      (commit),
      .sample_tick (sample_tick),
      .b_coef      (b_coef),
      .a_coef      (a_coef),
      .order       (order),
      .coef_valid  (coef_valid),
      .pending     (pending),
      .err         (err),
      .swap_count  (swap_count),
      .state_dbg   (state_dbg)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Host-side model
   logic [W-1:0] m_b [NB];
   logic [W-1:0] m_a [NA];
   logic [3:0]   m_order;
   logic [7:0]   m_swaps;
   bit           m_pend;

   logic [EW-1:0] exp_q [$];
   logic [EW-1:0] out_word;
   logic [EW-1:0] last_obs;
   bit            mon_en = 1'b0;

   assign out_word = {coef_valid, swap_count, order, a_coef, b_coef};

   function automatic logic [EW-1:0] pack_exp(input logic [7:0] sc);
      logic [NB*W-1:0] eb;
      logic [NA*W-1:0] ea;
      for (int i = 0; i < NB; i++) eb[i*W +: W] = m_b[i];
      for (int i = 0; i < NA; i++) ea[i*W +: W] = m_a[i];
      return {1'b1, sc, m_order, ea, eb};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NB; i++) m_b[i] = '0;
      for (int i = 0; i < NA; i++) m_a[i] = '0;
      m_order = '0;
      m_swaps = '0;
      m_pend  = 1'b0;
   endtask

   // Scoreboard monitor: any change of the active outputs must be a predicted swap
   always @(negedge clk) begin
      if (mon_en && (out_word !== last_obs)) begin
         if (exp_q.size() > 0) check_eq("swap_outputs", out_word, exp_q.pop_front());
         else                  check_eq("unexpected_change", out_word, last_obs);
         last_obs = out_word;
      end
   end

   // Driver: one clock cycle of stimulus, with model update and per-cycle checks
   task automatic cyc(input bit v, input logic [5:0] a, input logic [W-1:0] d,
                      input bit c, input bit t);
      bit acc;
      bit bad;
      bit was_pend;
      @(negedge clk);
      wr_valid = v; wr_addr = a; wr_data = d; commit = c; sample_tick = t;
      check_eq("wr_ready", EW'(wr_ready), EW'(!m_pend));
      check_eq("pending", EW'(pending), EW'(m_pend));
      check_eq("state_dbg", EW'(state_dbg), EW'(m_pend));
      was_pend = m_pend;
      acc = v && !m_pend;
      bad = (a > 6'd35) || ((a == 6'd35) && (d[3:0] > 4'd10));
      if (acc && !bad) begin
         if (int'(a) < NB)           m_b[a] = d;
         else if (int'(a) < NB + NA) m_a[int'(a) - NB] = d;
         else                        m_order = d[3:0];
      end
      if (was_pend && t) begin
         m_swaps = m_swaps + 8'd1;
         exp_q.push_back(pack_exp(m_swaps));
         m_pend = 1'b0;
      end else if (!was_pend && c) begin
         m_pend = 1'b1;
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0; commit = 1'b0; sample_tick = 1'b0;
      check_eq("err", EW'(err), EW'(acc && bad));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, '0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic apply_reset();
      @(negedge clk);
      #1 mon_en = 1'b0;
      #1 reset = 1'b0;
      #1;
      check_eq("rst_outputs", out_word, '0);
      check_eq("rst_pending", EW'(pending), '0);
      check_eq("rst_err", EW'(err), '0);
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      last_obs = out_word;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      check_eq("ready_after_rst", EW'(wr_ready), EW'(1));
   endtask

   initial begin
      reset = 1'b0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; sample_tick = 1'b0;
      model_clear();
      last_obs = '0;
      apply_reset();

      // Basic load, commit, tick
      cyc(1, 6'd0,  16'd5,    0, 0);
      cyc(1, 6'd1,  16'd8,    0, 0);
      cyc(1, 6'd2,  16'd5,    0, 0);
      cyc(1, 6'd21, 16'hF8E2, 0, 0);
      cyc(1, 6'd22, 16'h07EB, 0, 0);
      cyc(1, 6'd35, 16'd2,    0, 0);
      cyc(0, 6'd0,  '0,       1, 0);
      idle(2);
      cyc(0, 6'd0,  '0,       0, 1);
      check_eq("b0", EW'(b_coef[15:0]), EW'(16'd5));
      check_eq("b1", EW'(b_coef[31:16]), EW'(16'd8));
      check_eq("a1", EW'(a_coef[15:0]), EW'(16'hF8E2));
      check_eq("order", EW'(order), EW'(4'd2));
      check_eq("coef_valid", EW'(coef_valid), EW'(1));
      check_eq("swap_count", EW'(swap_count), EW'(8'd1));

      // Long pending: shadow frozen, writes held off
      cyc(0, 6'd0, '0, 1, 0);
      for (int i = 0; i < 50; i++) cyc(1, 6'd1, 16'hBEEF, 0, 0);
      cyc(0, 6'd0, '0, 0, 1);
      check_eq("b1_frozen", EW'(b_coef[31:16]), EW'(16'd8));

      // Rejected writes: unmapped address and illegal order
      cyc(1, 6'd40, 16'h1111, 0, 0);
      idle(1);
      cyc(1, 6'd35, 16'd12, 0, 0);
      idle(1);
      cyc(1, 6'd63, 16'h2222, 0, 0);
      cyc(0, 6'd0, '0, 1, 0);
      cyc(0, 6'd0, '0, 0, 1);
      check_eq("order_kept", EW'(order), EW'(4'd2));

      // Commit coinciding with tick: swap only on the following tick
      cyc(1, 6'd1, 16'h0055, 0, 0);
      cyc(0, 6'd0, '0, 1, 1);
      idle(3);
      cyc(0, 6'd0, '0, 0, 1);
      // Write in the same cycle as commit is part of the committed bank
      cyc(1, 6'd2, 16'h0077, 1, 0);
      cyc(0, 6'd0, '0, 1, 1);
      check_eq("b2_with_commit", EW'(b_coef[47:32]), EW'(16'h0077));
      // Tick while idle leaves active bank alone
      cyc(1, 6'd3, 16'h0999, 0, 1);
      idle(2);

      // Reset during PENDING discards commit and shadow
      cyc(1, 6'd4, 16'hABCD, 0, 0);
      cyc(0, 6'd0, '0, 1, 0);
      idle(1);
      apply_reset();
      cyc(0, 6'd0, '0, 0, 1);
      cyc(0, 6'd0, '0, 0, 1);
      idle(2);
      cyc(0, 6'd0, '0, 1, 0);
      cyc(0, 6'd0, '0, 0, 1);
      check_eq("shadow_cleared", EW'(b_coef[79:64]), EW'(16'd0));

      // 256 commit/tick pairs from reset: swap_count wraps to 0
      apply_reset();
      for (int k = 0; k < 256; k++) begin
         cyc(1, 6'($urandom_range(0, 35)), W'($urandom), 1, 0);
         cyc(0, 6'd0, '0, 0, 1);
      end
      idle(2);
      check_eq("swap_wrap", EW'(swap_count), EW'(8'd0));
      check_eq("valid_after_wrap", EW'(coef_valid), EW'(1));

      idle(2);
      check_eq("queue_drained", EW'(exp_q.size()), EW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
